// File: rtl/led_mmio_pkg.sv
// Shared definitions for the LED MMIO controller: register offsets, CTRL bit
// positions and the tick generator state encoding.
package led_mmio_pkg;

  // Byte offsets of the registers relative to BASE_ADDR.
  localparam logic [3:0] OFF_CTRL    = 4'h0;
  localparam logic [3:0] OFF_PERIOD  = 4'h4;
  localparam logic [3:0] OFF_PATTERN = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;

  typedef enum logic [1:0] {
    TickIdle,
    TickRun,
    TickPulse
  } tick_state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaled tick generator: while en_run is high, emits a one-cycle pulse
// every period+2 cycles; pulse is a registered copy of the PULSE state.
module led_tick_gen
  import led_mmio_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_run,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  pulse
);

  tick_state_e           state;
  logic [PRESCALE_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= TickIdle;
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (!en_run) begin
      state <= TickIdle;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      unique case (state)
        TickIdle: begin
          state <= TickRun;
          cnt   <= '0;
          pulse <= 1'b0;
        end
        TickRun: begin
          // >= so that lowering period below cnt fires on the next cycle.
          if (cnt >= period) begin
            state <= TickPulse;
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            pulse <= 1'b0;
          end
        end
        TickPulse: begin
          state <= TickRun;
          cnt   <= '0;
          pulse <= 1'b0;
        end
        default: begin
          state <= TickIdle;
          cnt   <= '0;
          pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED controller: valid/ready register bus plus the data_out
// byte stream. Define LED_MMIO_READBACK_EN to make mapped reads return contents.
module led_mmio_ctrl
  import led_mmio_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR  = 32'h0000_4000,
  parameter int unsigned           PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0] RST_PERIOD = 24'd49_999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  data_out
);

  logic                  accept;
  logic                  mapped;
  logic                  wr_en;
  logic [29:0]           word_off;
  logic [3:0]            reg_off;
  logic [1:0]            ctrl_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [7:0]            pattern_q;
  logic [7:0]            pcnt_q;
  logic                  en_run;
  logic                  pulse;
  logic [31:0]           rdata_d;
  logic                  unused_wdata;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // BASE_ADDR is taken as word aligned; misalignment is judged on the raw address.
  assign word_off = req_addr[31:2] - BASE_ADDR[31:2];
  assign mapped   = (req_addr[1:0] == 2'b00) && (word_off[29:2] == '0);
  assign reg_off  = {word_off[1:0], 2'b00};
  assign wr_en    = accept && req_we && mapped;

  assign unused_wdata = ^req_wdata[31:PRESCALE_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      period_q  <= RST_PERIOD;
      pattern_q <= '0;
    end else if (wr_en) begin
      unique case (reg_off)
        OFF_CTRL:    ctrl_q    <= req_wdata[1:0];
        OFF_PERIOD:  period_q  <= req_wdata[PRESCALE_W-1:0];
        OFF_PATTERN: pattern_q <= req_wdata[7:0];
        default:     ;
      endcase
    end
  end

  // A STATUS write beats a coincident pulse increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (wr_en && (reg_off == OFF_STATUS)) begin
      pcnt_q <= '0;
    end else if (pulse) begin
      pcnt_q <= pcnt_q + 8'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
`ifdef LED_MMIO_READBACK_EN
    if (mapped) begin
      unique case (reg_off)
        OFF_CTRL:    rdata_d = {30'b0, ctrl_q};
        OFF_PERIOD:  rdata_d[PRESCALE_W-1:0] = period_q;
        OFF_PATTERN: rdata_d = {24'b0, pattern_q};
        OFF_STATUS:  rdata_d = {24'b0, pcnt_q};
        default:     rdata_d = '0;
      endcase
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_we ? 32'h0 : rdata_d;
      rsp_err   <= !mapped;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign en_run = ctrl_q[CTRL_EN] && ctrl_q[CTRL_MODE];

  led_tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .en_run(en_run),
    .period(period_q),
    .pulse (pulse)
  );

  // Decodes flops only, so no req_* path reaches data_out within a cycle.
  always_comb begin
    data_out = 8'h00;
    if (ctrl_q[CTRL_EN]) begin
      data_out = ctrl_q[CTRL_MODE] ? {7'b0, pulse} : pattern_q;
    end
  end

endmodule
